// File: rtl/mp_add_pkg.sv
// Shared types for the multi-precision add/subtract sequencer.
package mp_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/mp_word_adder.sv
// Combinational W-bit ripple word adder with carry in/out.
module mp_word_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c,
  output logic [W-1:0] o_sum,
  output logic         o_c
);
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_c};
endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add/subtract, LS word first, single-entry output register.
// Optional signed-overflow flag is built only when MP_ADD_OVF_EN is defined.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int W         = 64,
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = $clog2(MAX_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [LEN_W-1:0] nwords,
  output logic             busy,
  output logic             done,
  input  logic [W-1:0]     a_data,
  input  logic [W-1:0]     b_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     s_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             s_last,
  output logic             carry_out,
  output logic             ovf
);
  localparam logic [LEN_W:0] ONE  = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] MAXL = (LEN_W+1)'(MAX_WORDS);

  state_t         r_state, w_next;
  logic           r_sub, r_carry, r_cout;
  logic [LEN_W:0] r_len, r_cnt;
  logic [W-1:0]   r_s_data;
  logic           r_s_valid, r_s_last;

  logic [W-1:0]   w_beff, w_sum;
  logic           w_c, w_acc, w_pop, w_is_last, w_start;

  assign w_start   = (r_state == IDLE) && start;
  assign w_acc     = in_valid && in_ready;
  assign w_pop     = r_s_valid && s_ready;
  assign w_is_last = (r_cnt == r_len - ONE);
  assign w_beff    = (r_sub == OP_SUB) ? ~b_data : b_data;

  mp_word_adder #(.W(W)) u_add (
    .i_a  (a_data),
    .i_b  (w_beff),
    .i_c  (r_carry),
    .o_sum(w_sum),
    .o_c  (w_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_acc && w_is_last) w_next = DRAIN;
      DRAIN:   if (w_pop && r_s_last) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != IDLE);
    done     = (r_state == FIN);
    in_ready = (r_state == RUN) && (!r_s_valid || s_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub     <= OP_ADD;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_s_data  <= '0;
      r_s_valid <= 1'b0;
      r_s_last  <= 1'b0;
    end else begin
      if (w_start) begin
        r_sub   <= sub;
        r_len   <= (nwords == '0) ? MAXL : {1'b0, nwords};
        r_cnt   <= '0;
        r_carry <= sub;  // +1 of the two's-complement negate for subtract
        r_cout  <= 1'b0;
      end
      if (w_acc) begin
        r_s_data  <= w_sum;
        r_s_valid <= 1'b1;
        r_s_last  <= w_is_last;
        r_carry   <= w_c;
        r_cnt     <= r_cnt + ONE;
        if (w_is_last) r_cout <= w_c;
      end else if (w_pop) begin
        r_s_valid <= 1'b0;
        r_s_last  <= 1'b0;
      end
    end
  end

`ifdef MP_ADD_OVF_EN
  logic r_ovf, w_ovf;
  // carry into the MSB xor carry out of it
  assign w_ovf = a_data[W-1] ^ w_beff[W-1] ^ w_sum[W-1] ^ w_c;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_ovf <= 1'b0;
    else if (w_start)           r_ovf <= 1'b0;
    else if (w_acc && w_is_last) r_ovf <= w_ovf;
  end
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign s_data    = r_s_data;
  assign s_valid   = r_s_valid;
  assign s_last    = r_s_last;
  assign carry_out = r_cout;
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq at W=8, MAX_WORDS=4.
module tb_mp_add_seq;
  localparam int W = 8, MW = 4, LW = 2;
`ifdef MP_ADD_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
  logic [LW-1:0] nwords = '0;
  logic [W-1:0]  a_data = '0, b_data = '0;
  logic          in_valid = 1'b0, s_ready = 1'b0;
  logic          busy, done, in_ready, s_valid, s_last, carry_out, ovf;
  logic [W-1:0]  s_data;

  int checks = 0, errors = 0;
  logic [8:0] exp_q[$];

  mp_add_seq #(.W(W), .MAX_WORDS(MW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .nwords(nwords),
    .busy(busy), .done(done), .a_data(a_data), .b_data(b_data),
    .in_valid(in_valid), .in_ready(in_ready), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .s_last(s_last), .carry_out(carry_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // reference: full-length arithmetic on the masked operands, signed ovf by sign rule
  function automatic logic [33:0] model(input logic op, input int len, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, bb, res;
    logic [32:0] s;
    logic sa, sb, sr, o;
    int msb;
    mask = (len == 4) ? 32'hFFFF_FFFF : ((32'h1 << (len*8)) - 32'h1);
    bb   = op ? ~b : b;
    s    = {1'b0, a & mask} + {1'b0, bb & mask} + {32'h0, op};
    res  = s[31:0] & mask;
    msb  = len*8 - 1;
    sa = a[msb]; sb = b[msb]; sr = res[msb];
    o  = op ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {o, s[len*8], res};
  endfunction

  task automatic do_op(input logic op, input logic [1:0] nw, input logic [31:0] a, input logic [31:0] b,
                       input bit bp, input bit hold, input logic [31:0] er, input logic ec, input logic eo);
    int len, widx, nout, ndone, cyc;
    logic pv, pr;
    logic [7:0] pd;
    logic [8:0] e;
    exp_q.delete();
    len = (nw == 2'd0) ? 4 : int'(nw);
    @(negedge clk);
    start = 1'b1; sub = op; nwords = nw; in_valid = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    sub = ~op; nwords = ~nw;
    #1 chk("busy_run", busy, 1);
    widx = 0; nout = 0; ndone = 0; pv = 1'b0; pr = 1'b1; pd = '0;
    for (cyc = 0; cyc < 200 && !(nout == len && ndone > 0); cyc++) begin
      s_ready = bp ? cyc[0] : 1'b1;
      if (widx < len) begin
        in_valid = 1'b1; a_data = a[8*widx +: 8]; b_data = b[8*widx +: 8];
      end else begin
        in_valid = 1'b0; a_data = W'($urandom); b_data = W'($urandom);
      end
      #1;
      if (pv && !pr) begin
        chk("stall_vld", s_valid, 1);
        chk("stall_data", s_data, pd);
      end
      if (s_valid && !s_ready) chk("bp_in_ready", in_ready, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back({(widx == len-1), er[8*widx +: 8]});
        widx++;
      end
      if (s_valid && s_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", {s_last, s_data}, 9'h1ff);
        else begin
          e = exp_q.pop_front();
          chk("s_word", {s_last, s_data}, e);
        end
        nout++;
      end
      if (done) begin
        ndone++;
        if (hold) start = 1'b0;
      end
      pv = s_valid; pr = s_ready; pd = s_data;
      @(negedge clk);
    end
    chk("complete", {nout[7:0], ndone[7:0]}, {len[7:0], 8'd1});
    in_valid = 1'b1; s_ready = 1'b1;
    #1 chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    @(negedge clk);
    #1 chk("no_2nd_done", done, 0);
    chk("idle_s_valid", s_valid, 0);
    in_valid = 1'b0;
    chk("carry_out", carry_out, ec);
    chk("ovf", ovf, eo & OVF_EN);
  endtask

  initial begin
    logic [33:0] m;
    logic op;
    logic [1:0] nw;
    logic [31:0] ra, rb;
    #12 chk("rst_outs", {busy, done, in_ready, s_valid, s_last, carry_out, ovf, s_data}, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(1'b0, 2'd2, 32'h01FF, 32'h0001, 1'b0, 1'b0, 32'h0200, 1'b0, 1'b0);
    do_op(1'b1, 2'd2, 32'h0100, 32'h0001, 1'b0, 1'b0, 32'h00FF, 1'b1, 1'b0);
    do_op(1'b1, 2'd2, 32'h0001, 32'h0100, 1'b0, 1'b0, 32'hFF01, 1'b0, 1'b0);
    do_op(1'b0, 2'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    do_op(1'b0, 2'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op(1'b0, 2'd3, 32'h12_3456, 32'h0F_EDCB, 1'b1, 1'b0, 32'h22_2221, 1'b0, 1'b0);
    do_op(1'b0, 2'd1, 32'hFF, 32'h01, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0);

    // reset with one word of a 3-word add held in the output register
    @(negedge clk); start = 1'b1; sub = 1'b0; nwords = 2'd3; s_ready = 1'b0;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; a_data = 8'h11; b_data = 8'h22;
    #1 chk("mid_in_ready", in_ready, 1);
    @(negedge clk); in_valid = 1'b0;
    #1 chk("mid_word", {s_valid, s_data}, 9'h133);
    rst_n = 1'b0;
    #1 chk("mid_rst_outs", {busy, done, in_ready, s_valid, s_last, carry_out, ovf, s_data}, 0);
    @(negedge clk); rst_n = 1'b1; s_ready = 1'b1;
    do_op(1'b0, 2'd1, 32'h05, 32'h07, 1'b0, 1'b0, 32'h0C, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      op = 1'($urandom_range(0, 1));
      nw = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      m  = model(op, (nw == 2'd0) ? 4 : int'(nw), ra, rb);
      do_op(op, nw, ra, rb, i[0], 1'b0, m[31:0], m[32], m[33]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
